// File: rtl/rc5_pkg.sv
// Shared definitions for the RC5 engine controller.
//   W, R, T, T_LENGTH : default word width, round count, S-table size and S-address width
//   ctrlState_t       : controller state encoding
//   MODE_ENC/MODE_DEC : request mode bit values
package rc5_pkg;

  localparam int W        = 32;
  localparam int R        = 12;
  localparam int T        = 2 * (R + 1);
  localparam int T_LENGTH = $clog2(T);

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENG_RST = 3'd1,
    ST_START   = 3'd2,
    ST_RUN     = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_RESP    = 3'd5
  } ctrlState_t;

endpackage

// File: rtl/rc5_watchdog.sv
// Watchdog counter for the RUN phase of an engine operation.
//   clk, rst  : clock, asynchronous active-high reset
//   iClear    : forces the count to zero (has priority)
//   iEnable   : advances the count by one per cycle
//   oExpired  : high while the count sits at TIMEOUT-1 (last allowed cycle)
module rc5_watchdog #(
  parameter int TIMEOUT = 512
) (
  input  logic clk,
  input  logic rst,
  input  logic iClear,
  input  logic iEnable,
  output logic oExpired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (iClear) begin
      count <= '0;
    end else if (iEnable) begin
      count <= count + 1'b1;
    end
  end

  assign oExpired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/rc5_engine_ctrl.sv
// Request scheduler for the RC5 encipher/decipher engines sharing one S table.
//   clk, rst                  : clock, asynchronous active-high reset
//   iKey_ready                : S table valid; gates new accepts only
//   iReq_valid/oReq_ready     : request handshake; iReq_mode 0=enc 1=dec, iReq_A/B block
//   oResp_valid/iResp_ready   : response handshake; oResp_A/B result, oResp_err watchdog abort
//   oEnc_rst/oDec_rst         : per-engine synchronous reset (unselected engine always held)
//   oEnc_start/oDec_start     : one-cycle start pulse
//   oEng_A/oEng_B             : block words broadcast to both engines
//   iEnc_addr*/iDec_addr*     : engine S-table read addresses
//   oS_address1/2             : selected engine's addresses to the shared table
//   iEnc_done/iDec_done       : sticky done from engines; iEnc_A/B, iDec_A/B results
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for a request; ready follows iKey_ready
// ST_ENG_RST | selected engine held in reset for one full cycle
// ST_START   | selected engine released, start pulse high
// ST_RUN     | engine running, watchdog counting
// ST_SETTLE  | done seen, waiting for engine results to stabilise
// ST_RESP    | response presented until the consumer takes it
module rc5_engine_ctrl
  import rc5_pkg::*;
#(
  parameter int W        = rc5_pkg::W,
  parameter int R        = rc5_pkg::R,
  parameter int SETTLE   = 4,
  parameter int TIMEOUT  = 512,
  parameter int T_LENGTH = $clog2(2 * (R + 1))
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iKey_ready,
  input  logic                iReq_valid,
  output logic                oReq_ready,
  input  logic                iReq_mode,
  input  logic [W-1:0]        iReq_A,
  input  logic [W-1:0]        iReq_B,
  output logic                oResp_valid,
  input  logic                iResp_ready,
  output logic [W-1:0]        oResp_A,
  output logic [W-1:0]        oResp_B,
  output logic                oResp_err,
  output logic                oEnc_rst,
  output logic                oDec_rst,
  output logic                oEnc_start,
  output logic                oDec_start,
  output logic [W-1:0]        oEng_A,
  output logic [W-1:0]        oEng_B,
  input  logic [T_LENGTH-1:0] iEnc_addr1,
  input  logic [T_LENGTH-1:0] iEnc_addr2,
  input  logic [T_LENGTH-1:0] iDec_addr1,
  input  logic [T_LENGTH-1:0] iDec_addr2,
  output logic [T_LENGTH-1:0] oS_address1,
  output logic [T_LENGTH-1:0] oS_address2,
  input  logic                iEnc_done,
  input  logic                iDec_done,
  input  logic [W-1:0]        iEnc_A,
  input  logic [W-1:0]        iEnc_B,
  input  logic [W-1:0]        iDec_A,
  input  logic [W-1:0]        iDec_B
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  ctrlState_t    state;
  logic          rMode;
  logic [SW-1:0] settleCnt;
  logic          wdExpired;
  logic          selDone;
  logic [W-1:0]  selA;
  logic [W-1:0]  selB;

  assign selDone = (rMode == MODE_DEC) ? iDec_done : iEnc_done;
  assign selA    = (rMode == MODE_DEC) ? iDec_A    : iEnc_A;
  assign selB    = (rMode == MODE_DEC) ? iDec_B    : iEnc_B;

  assign oReq_ready  = (state == ST_IDLE) && iKey_ready;
  assign oS_address1 = rMode ? iDec_addr1 : iEnc_addr1;
  assign oS_address2 = rMode ? iDec_addr2 : iEnc_addr2;

  // Count is held at zero outside RUN, so each operation starts fresh.
  rc5_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) uWatchdog (
    .clk      (clk),
    .rst      (rst),
    .iClear   (state != ST_RUN),
    .iEnable  (state == ST_RUN),
    .oExpired (wdExpired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rMode       <= MODE_ENC;
      settleCnt   <= '0;
      oEng_A      <= '0;
      oEng_B      <= '0;
      oResp_valid <= 1'b0;
      oResp_A     <= '0;
      oResp_B     <= '0;
      oResp_err   <= 1'b0;
      oEnc_start  <= 1'b0;
      oDec_start  <= 1'b0;
      oEnc_rst    <= 1'b1;
      oDec_rst    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iReq_valid && oReq_ready) begin
            rMode  <= iReq_mode;
            oEng_A <= iReq_A;
            oEng_B <= iReq_B;
            state  <= ST_ENG_RST;
          end
        end
        ST_ENG_RST: begin
          if (rMode == MODE_DEC) begin
            oDec_rst   <= 1'b0;
            oDec_start <= 1'b1;
          end else begin
            oEnc_rst   <= 1'b0;
            oEnc_start <= 1'b1;
          end
          state <= ST_START;
        end
        ST_START: begin
          oEnc_start <= 1'b0;
          oDec_start <= 1'b0;
          state      <= ST_RUN;
        end
        ST_RUN: begin
          // done is checked first so a completion on the last watchdog cycle still counts
          if (selDone) begin
            settleCnt <= SW'(SETTLE - 1);
            state     <= ST_SETTLE;
          end else if (wdExpired) begin
            oResp_err   <= 1'b1;
            oResp_A     <= '0;
            oResp_B     <= '0;
            oResp_valid <= 1'b1;
            oEnc_rst    <= 1'b1;
            oDec_rst    <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_SETTLE: begin
          if (settleCnt == '0) begin
            oResp_err   <= 1'b0;
            oResp_A     <= selA;
            oResp_B     <= selB;
            oResp_valid <= 1'b1;
            oEnc_rst    <= 1'b1;
            oDec_rst    <= 1'b1;
            state       <= ST_RESP;
          end else begin
            settleCnt <= settleCnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (iResp_ready) begin
            oResp_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc5_engine_ctrl.sv
// Bench for rc5_engine_ctrl: RC5-32/12/16 reference with an all-zero key,
// behavioural engine models on the engine ports, directed and random requests.
module tb_rc5_engine_ctrl;
  import rc5_pkg::*;

  localparam int SETTLE_C  = 4;
  localparam int TIMEOUT_C = 512;
  localparam int TL        = T_LENGTH;

  logic          clk;
  logic          rst;
  logic          iKey_ready;
  logic          iReq_valid;
  logic          oReq_ready;
  logic          iReq_mode;
  logic [31:0]   iReq_A, iReq_B;
  logic          oResp_valid;
  logic          iResp_ready;
  logic [31:0]   oResp_A, oResp_B;
  logic          oResp_err;
  logic          oEnc_rst, oDec_rst, oEnc_start, oDec_start;
  logic [31:0]   oEng_A, oEng_B;
  logic [TL-1:0] iEnc_addr1, iEnc_addr2, iDec_addr1, iDec_addr2;
  logic [TL-1:0] oS_address1, oS_address2;
  logic          iEnc_done, iDec_done;
  logic [31:0]   iEnc_A, iEnc_B, iDec_A, iDec_B;

  rc5_engine_ctrl #(
    .SETTLE  (SETTLE_C),
    .TIMEOUT (TIMEOUT_C)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .iKey_ready  (iKey_ready),
    .iReq_valid  (iReq_valid),
    .oReq_ready  (oReq_ready),
    .iReq_mode   (iReq_mode),
    .iReq_A      (iReq_A),
    .iReq_B      (iReq_B),
    .oResp_valid (oResp_valid),
    .iResp_ready (iResp_ready),
    .oResp_A     (oResp_A),
    .oResp_B     (oResp_B),
    .oResp_err   (oResp_err),
    .oEnc_rst    (oEnc_rst),
    .oDec_rst    (oDec_rst),
    .oEnc_start  (oEnc_start),
    .oDec_start  (oDec_start),
    .oEng_A      (oEng_A),
    .oEng_B      (oEng_B),
    .iEnc_addr1  (iEnc_addr1),
    .iEnc_addr2  (iEnc_addr2),
    .iDec_addr1  (iDec_addr1),
    .iDec_addr2  (iDec_addr2),
    .oS_address1 (oS_address1),
    .oS_address2 (oS_address2),
    .iEnc_done   (iEnc_done),
    .iDec_done   (iDec_done),
    .iEnc_A      (iEnc_A),
    .iEnc_B      (iEnc_B),
    .iDec_A      (iDec_A),
    .iDec_B      (iDec_B)
  );

  int passCnt  = 0;
  int totalCnt = 0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- RC5-32/12 reference ----------------
  logic [31:0] S [0:25];

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
    int sh;
    sh = int'(s);
    return (x << sh) | (x >> (32 - sh));
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] s);
    int sh;
    sh = int'(s);
    return (x >> sh) | (x << (32 - sh));
  endfunction

  task automatic initKey();
    logic [31:0] L [0:3];
    logic [31:0] a, b, ab;
    int i, j;
    S[0] = 32'hB7E15163;
    for (int k = 1; k < 26; k++) S[k] = S[k-1] + 32'h9E3779B9;
    for (int k = 0; k < 4; k++) L[k] = '0;
    a = '0; b = '0; i = 0; j = 0;
    for (int k = 0; k < 78; k++) begin
      a = rotl(S[i] + a + b, 5'd3);
      S[i] = a;
      ab = a + b;
      b = rotl(L[j] + ab, ab[4:0]);
      L[j] = b;
      i = (i + 1) % 26;
      j = (j + 1) % 4;
    end
  endtask

  function automatic logic [63:0] rc5Enc(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    x = a + S[0];
    y = b + S[1];
    for (int r = 1; r <= 12; r++) begin
      x = rotl(x ^ y, y[4:0]) + S[2*r];
      y = rotl(y ^ x, x[4:0]) + S[2*r+1];
    end
    return {x, y};
  endfunction

  function automatic logic [63:0] rc5Dec(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    x = a;
    y = b;
    for (int r = 12; r >= 1; r--) begin
      y = rotr(y - S[2*r+1], x[4:0]) ^ x;
      x = rotr(x - S[2*r], y[4:0]) ^ y;
    end
    return {x - S[0], y - S[1]};
  endfunction

  // ---------------- engine models ----------------
  // Engine e (0 = enc, 1 = dec): after start, raises done engLat cycles later
  // (never if engHang), and only presents its true result SETTLE cycles after done.
  int          engLat  = 5;
  bit          engHang = 0;
  logic [1:0]  engDone;
  logic [31:0] engResA [2];
  logic [31:0] engResB [2];
  bit          busy [2];
  bit          hung [2];
  int          cnt [2];
  int          settle [2];
  logic [63:0] fin [2];

  assign iEnc_done = engDone[0];
  assign iDec_done = engDone[1];
  assign iEnc_A    = engResA[0];
  assign iEnc_B    = engResB[0];
  assign iDec_A    = engResA[1];
  assign iDec_B    = engResB[1];

  initial begin
    engDone = '0;
    for (int e = 0; e < 2; e++) begin
      busy[e] = 0; hung[e] = 0; cnt[e] = 0; settle[e] = 0;
      engResA[e] = '0; engResB[e] = '0; fin[e] = '0;
    end
    iEnc_addr1 = '0; iEnc_addr2 = '0; iDec_addr1 = '0; iDec_addr2 = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int e = 0; e < 2; e++) begin
        logic eRst, eStart;
        eRst   = (e == 0) ? oEnc_rst : oDec_rst;
        eStart = (e == 0) ? oEnc_start : oDec_start;
        if (eRst) begin
          busy[e] = 0;
          engDone[e] = 1'b0;
        end else if (eStart) begin
          busy[e] = 1;
          hung[e] = engHang;
          cnt[e] = engLat;
          engDone[e] = 1'b0;
          fin[e] = (e == 0) ? rc5Enc(oEng_A, oEng_B) : rc5Dec(oEng_A, oEng_B);
        end else if (busy[e]) begin
          if (!engDone[e]) begin
            if (!hung[e]) begin
              cnt[e]--;
              if (cnt[e] == 0) begin
                engDone[e] = 1'b1;
                settle[e] = SETTLE_C;
              end
            end
          end else if (settle[e] > 0) begin
            settle[e]--;
          end
        end
        if (busy[e] && engDone[e] && settle[e] == 0) begin
          engResA[e] = fin[e][63:32];
          engResB[e] = fin[e][31:0];
        end else begin
          engResA[e] = $urandom;
          engResB[e] = $urandom;
        end
      end
      iEnc_addr1 = TL'($urandom_range(0, 25));
      iEnc_addr2 = TL'($urandom_range(0, 25));
      iDec_addr1 = TL'($urandom_range(0, 25));
      iDec_addr2 = TL'($urandom_range(0, 25));
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  // ---------------- transaction ----------------
  task automatic runTxn(input logic mode, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input bit hang, input int hold, input int keyDelay,
                        output logic [64:0] resp);
    logic [64:0] expResp;
    bit accepted, ok, stable;
    int n, starts, rstBad, addrBad;
    engLat  = lat;
    engHang = hang;
    expResp = hang ? {1'b1, 64'h0} : {1'b0, (mode ? rc5Dec(a, b) : rc5Enc(a, b))};
    @(negedge clk);
    iReq_valid = 1'b1; iReq_mode = mode; iReq_A = a; iReq_B = b;
    if (keyDelay > 0) begin
      iKey_ready = 1'b0;
      ok = 1;
      for (int i = 0; i < keyDelay; i++) begin
        @(negedge clk);
        if (oReq_ready !== 1'b0) ok = 0;
      end
      check("key_block", ok, 1);
      iKey_ready = 1'b1;
    end
    accepted = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (oReq_ready === 1'b1) begin
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    check("accept", accepted, 1);
    @(negedge clk);
    iReq_valid = 1'b0;
    iReq_mode  = 1'($urandom);
    iReq_A     = $urandom;
    iReq_B     = $urandom;
    check("ready_busy", oReq_ready, 0);
    check("eng_words", {oEng_A, oEng_B}, {a, b});
    n = 1; starts = 0; rstBad = 0; addrBad = 0;
    while (n < 3 + TIMEOUT_C + SETTLE_C + 20) begin
      if ((mode ? oDec_start : oEnc_start) === 1'b1) starts++;
      if ((mode ? oEnc_start : oDec_start) !== 1'b0) rstBad++;
      if ((mode ? oEnc_rst : oDec_rst) !== 1'b1) rstBad++;
      if (oS_address1 !== (mode ? iDec_addr1 : iEnc_addr1)) addrBad++;
      if (oS_address2 !== (mode ? iDec_addr2 : iEnc_addr2)) addrBad++;
      if (oResp_valid === 1'b1) break;
      @(negedge clk);
      n++;
    end
    check("resp_valid", oResp_valid, 1);
    check("latency", n, hang ? 3 + TIMEOUT_C : 3 + lat + SETTLE_C);
    check("start_pulses", starts, 1);
    check("unsel_engine", rstBad, 0);
    check("s_addr_mux", addrBad, 0);
    check("sel_rst_in_resp", mode ? oDec_rst : oEnc_rst, 1);
    resp = {oResp_err, oResp_A, oResp_B};
    check("resp_data", resp, expResp);
    if (hold > 0) begin
      stable = 1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (oResp_valid !== 1'b1 || {oResp_err, oResp_A, oResp_B} !== resp) stable = 0;
      end
      check("resp_hold", stable, 1);
    end
    iResp_ready = 1'b1;
    @(negedge clk);
    iResp_ready = 1'b0;
    check("resp_drop", oResp_valid, 0);
    check("ready_after_hs", oReq_ready, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [64:0] r;
    int noResp;
    rst = 1'b1; iKey_ready = 1'b0; iReq_valid = 1'b0; iReq_mode = 1'b0;
    iReq_A = '0; iReq_B = '0; iResp_ready = 1'b0;
    initKey();
    repeat (2) @(negedge clk);
    check("rst_eng_rst", {oEnc_rst, oDec_rst}, 2'b11);
    check("rst_start", {oEnc_start, oDec_start}, 2'b00);
    check("rst_resp", {oResp_valid, oResp_err, oResp_A, oResp_B}, '0);
    check("rst_eng_words", {oEng_A, oEng_B}, '0);
    check("rst_ready", oReq_ready, 0);
    check("rst_s_addr", {oS_address1, oS_address2}, {iEnc_addr1, iEnc_addr2});
    rst = 1'b0;
    @(negedge clk);
    iKey_ready = 1'b1;

    // known-answer encipher and its inverse
    runTxn(MODE_ENC, 32'h0, 32'h0, 10, 0, 0, 0, r);
    check("kat_enc", r, {1'b0, 32'hEEDBA521, 32'h6D8F4B15});
    runTxn(MODE_DEC, 32'hEEDBA521, 32'h6D8F4B15, 7, 0, 0, 0, r);
    check("kat_dec", r, {1'b0, 64'h0});

    // key not ready for 100 cycles
    runTxn(MODE_ENC, 32'h01234567, 32'h89ABCDEF, 3, 0, 0, 100, r);

    // consumer stalls 20 cycles, then immediate back-to-back request
    runTxn(MODE_DEC, 32'hCAFEF00D, 32'h12345678, 1, 0, 20, 0, r);
    runTxn(MODE_ENC, 32'hDEADBEEF, 32'h0BADC0DE, 2, 0, 0, 0, r);

    // hung decipher engine trips the watchdog, then recovery
    runTxn(MODE_DEC, 32'h11111111, 32'h22222222, 1, 1, 0, 0, r);
    runTxn(MODE_ENC, 32'h33333333, 32'h44444444, 12, 0, 0, 0, r);

    for (int k = 0; k < 8; k++) begin
      runTxn(1'($urandom), $urandom, $urandom, $urandom_range(1, 40), 0,
             $urandom_range(0, 3), 0, r);
    end

    // reset in the middle of RUN
    engLat = 200; engHang = 0;
    @(negedge clk);
    iReq_valid = 1'b1; iReq_mode = MODE_DEC; iReq_A = $urandom; iReq_B = $urandom;
    #1;
    check("rst_test_ready", oReq_ready, 1);
    @(negedge clk);
    iReq_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_run_dec_rst", oDec_rst, 0);
    #2 rst = 1'b1;
    #1;
    check("async_eng_rst", {oEnc_rst, oDec_rst}, 2'b11);
    check("async_start", {oEnc_start, oDec_start}, 2'b00);
    check("async_resp", {oResp_valid, oResp_err, oResp_A, oResp_B}, '0);
    check("async_eng_words", {oEng_A, oEng_B}, '0);
    check("async_s_addr", {oS_address1, oS_address2}, {iEnc_addr1, iEnc_addr2});
    @(negedge clk);
    rst = 1'b0;
    noResp = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (oResp_valid !== 1'b0) noResp++;
    end
    check("no_resp_after_rst", noResp, 0);
    check("idle_after_rst", oReq_ready, 1);
    runTxn(MODE_ENC, 32'h0, 32'h0, 4, 0, 0, 0, r);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
